// File: rtl/ctrl_pkt_pkg.sv
// ctrl_pkt_pkg
// Shared definitions for the control-path packet transmitter: header field
// offsets inside the 256-bit header beat, the default header tag, the
// number of bytes carried by one bus beat, and the transmitter state enum.
package ctrl_pkt_pkg;

    // Bit offsets of the header fields within tdata of the header beat
    localparam int unsigned TAG_LSB   = 0;
    localparam int unsigned STAGE_LSB = 16;
    localparam int unsigned RES_LSB   = 24;
    localparam int unsigned IDX_LSB   = 32;
    localparam int unsigned NB_LSB    = 40;

    localparam logic [15:0] DEFAULT_CTRL_TAG = 16'hF2F1;

    // One 256-bit beat carries 32 bytes
    localparam int unsigned BYTES_PER_BEAT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_DATA,
        ST_GAP
    } state_e;

endpackage

// File: rtl/ctrl_payload_buf.sv
// ctrl_payload_buf
// Payload staging buffer: DEPTH x WIDTH register file, one synchronous write
// port and one combinational read port. Contents are not reset.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational from raddr_i)
module ctrl_payload_buf
    import ctrl_pkt_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 256,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ctrl_pkt_tx.sv
// ctrl_pkt_tx
// Control-path packet transmitter. Accepts a table-write command, buffers its
// payload words, then emits one gap-free AXI-Stream control packet (header
// beat followed by the payload beats), then holds the bus idle for at least
// GAP_CYCLES cycles before accepting the next command.
// Ports:
//   axis_clk, aresetn                  - clock, async active-low reset
//   cmd_stage_id/resource_id/index     - command target fields
//   cmd_nbeats                         - payload beats, legal 1..MAX_BEATS
//   cmd_valid / cmd_ready              - command handshake
//   wr_data, wr_data_valid/_ready      - payload word handshake
//   c_m_axis_t{data,user,keep,valid,last} - control stream (registered)
//   busy                               - high whenever not IDLE
//   pkt_done                           - pulse after a packet completes
//   cmd_err                            - pulse when a command is rejected
module ctrl_pkt_tx
    import ctrl_pkt_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned MAX_BEATS            = 4,
    parameter int unsigned GAP_CYCLES           = 2,
    parameter logic [15:0] CTRL_TAG             = DEFAULT_CTRL_TAG,
    localparam int unsigned NBW                 = $clog2(MAX_BEATS) + 1
) (
    input  logic                                axis_clk,
    input  logic                                aresetn,

    input  logic [7:0]                          cmd_stage_id,
    input  logic [7:0]                          cmd_resource_id,
    input  logic [7:0]                          cmd_index,
    input  logic [NBW-1:0]                      cmd_nbeats,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      wr_data,
    input  logic                                wr_data_valid,
    output logic                                wr_data_ready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep,
    output logic                                c_m_axis_tvalid,
    output logic                                c_m_axis_tlast,

    output logic                                busy,
    output logic                                pkt_done,
    output logic                                cmd_err
);

    localparam int unsigned AW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    localparam logic [NBW-1:0] MAX_NB   = NBW'(MAX_BEATS);
    localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES);

    state_e                              state_q;
    logic [7:0]                          stage_q;
    logic [7:0]                          res_q;
    logic [7:0]                          idx_q;
    logic [NBW-1:0]                      nbeats_q;
    logic [NBW-1:0]                      cnt_q;
    logic [GW-1:0]                       gap_q;

    logic [C_S_AXIS_DATA_WIDTH-1:0]      tdata_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]     tuser_q;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]    tkeep_q;
    logic                                tvalid_q;
    logic                                tlast_q;
    logic                                pkt_done_q;
    logic                                cmd_err_q;

    logic [C_S_AXIS_DATA_WIDTH-1:0]      hdr_word;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]     user_word;
    logic [C_S_AXIS_DATA_WIDTH-1:0]      buf_rdata;
    logic [NBW-1:0]                      nb_last;
    logic                                cmd_illegal;
    logic                                buf_we;

    assign cmd_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign wr_data_ready = (state_q == ST_LOAD);

    assign nb_last     = nbeats_q - NBW'(1);
    assign cmd_illegal = (cmd_nbeats == '0) || (cmd_nbeats > MAX_NB);
    assign buf_we      = (state_q == ST_LOAD) && wr_data_valid;

    always_comb begin
        hdr_word = '0;
        hdr_word[TAG_LSB   +: 16] = CTRL_TAG;
        hdr_word[STAGE_LSB +: 8]  = stage_q;
        hdr_word[RES_LSB   +: 8]  = res_q;
        hdr_word[IDX_LSB   +: 8]  = idx_q;
        hdr_word[NB_LSB    +: 8]  = 8'(nbeats_q);
    end

    // tuser carries the whole packet length in bytes, header included
    always_comb begin
        user_word = '0;
        user_word[15:0] = 16'((32'(nbeats_q) + 32'd1) * BYTES_PER_BEAT);
    end

    // Load and drain both walk the buffer with cnt_q, never at the same time
    ctrl_payload_buf #(
        .DEPTH (MAX_BEATS),
        .WIDTH (C_S_AXIS_DATA_WIDTH)
    ) u_buf (
        .clk_i   (axis_clk),
        .we_i    (buf_we),
        .waddr_i (cnt_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (cnt_q[AW-1:0]),
        .rdata_o (buf_rdata)
    );

    // Bus outputs lag the state by one cycle: the last data beat is on the
    // bus during the first GAP cycle, so GAP lasts GAP_CYCLES+1 state cycles
    // to give GAP_CYCLES idle bus cycles after tlast.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            res_q      <= '0;
            idx_q      <= '0;
            nbeats_q   <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tkeep_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            pkt_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            tdata_q    <= '0;
            tuser_q    <= '0;
            tkeep_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            pkt_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        stage_q  <= cmd_stage_id;
                        res_q    <= cmd_resource_id;
                        idx_q    <= cmd_index;
                        nbeats_q <= cmd_nbeats;
                        if (cmd_illegal) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    if (wr_data_valid) begin
                        if (cnt_q == nb_last) begin
                            cnt_q   <= '0;
                            state_q <= ST_HDR;
                        end else begin
                            cnt_q <= cnt_q + NBW'(1);
                        end
                    end
                end

                ST_HDR: begin
                    tvalid_q <= 1'b1;
                    tdata_q  <= hdr_word;
                    tuser_q  <= user_word;
                    tkeep_q  <= '1;
                    state_q  <= ST_DATA;
                end

                ST_DATA: begin
                    tvalid_q <= 1'b1;
                    tdata_q  <= buf_rdata;
                    tuser_q  <= user_word;
                    tkeep_q  <= '1;
                    if (cnt_q == nb_last) begin
                        tlast_q <= 1'b1;
                        cnt_q   <= '0;
                        gap_q   <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + NBW'(1);
                    end
                end

                ST_GAP: begin
                    if (gap_q == '0) begin
                        pkt_done_q <= 1'b1;
                    end
                    if (gap_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign c_m_axis_tdata  = tdata_q;
    assign c_m_axis_tuser  = tuser_q;
    assign c_m_axis_tkeep  = tkeep_q;
    assign c_m_axis_tvalid = tvalid_q;
    assign c_m_axis_tlast  = tlast_q;
    assign pkt_done        = pkt_done_q;
    assign cmd_err         = cmd_err_q;

endmodule

// File: tb/tb_ctrl_pkt_tx.sv
// tb_ctrl_pkt_tx
// Scoreboard bench for ctrl_pkt_tx: expected beats are queued when a command
// is issued and compared as the DUT puts beats on the control bus.
module tb_ctrl_pkt_tx;

    logic         clk;
    logic         aresetn;
    logic [7:0]   cmd_stage_id;
    logic [7:0]   cmd_resource_id;
    logic [7:0]   cmd_index;
    logic [2:0]   cmd_nbeats;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [255:0] wr_data;
    logic         wr_data_valid;
    logic         wr_data_ready;
    logic [255:0] c_m_axis_tdata;
    logic [127:0] c_m_axis_tuser;
    logic [31:0]  c_m_axis_tkeep;
    logic         c_m_axis_tvalid;
    logic         c_m_axis_tlast;
    logic         busy;
    logic         pkt_done;
    logic         cmd_err;

    ctrl_pkt_tx #(
        .C_S_AXIS_DATA_WIDTH  (256),
        .C_S_AXIS_TUSER_WIDTH (128),
        .MAX_BEATS            (4),
        .GAP_CYCLES           (2),
        .CTRL_TAG             (16'hF2F1)
    ) dut (
        .axis_clk        (clk),
        .aresetn         (aresetn),
        .cmd_stage_id    (cmd_stage_id),
        .cmd_resource_id (cmd_resource_id),
        .cmd_index       (cmd_index),
        .cmd_nbeats      (cmd_nbeats),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .wr_data         (wr_data),
        .wr_data_valid   (wr_data_valid),
        .wr_data_ready   (wr_data_ready),
        .c_m_axis_tdata  (c_m_axis_tdata),
        .c_m_axis_tuser  (c_m_axis_tuser),
        .c_m_axis_tkeep  (c_m_axis_tkeep),
        .c_m_axis_tvalid (c_m_axis_tvalid),
        .c_m_axis_tlast  (c_m_axis_tlast),
        .busy            (busy),
        .pkt_done        (pkt_done),
        .cmd_err         (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [127:0] u;
        logic         l;
    } beat_t;

    beat_t sb[$];

    int total = 0;
    int bad   = 0;

    // Monitor bookkeeping, sampled on the falling edge
    int           cyc         = 0;
    int           tlast_cyc   = 0;
    int           hdr_cyc     = 0;
    int           done_cyc    = 0;
    int           done_count  = 0;
    int           hdr_count   = 0;
    int           pkt_len     = 0;
    int           cur_len     = 0;
    int           last_gap    = 0;
    int           ready_delay = 0;
    int           bubbles     = 0;
    bit           in_pkt      = 0;
    logic         prev_rdy    = 1'b0;
    logic [255:0] last_hdr    = '0;
    logic [127:0] last_tuser  = '0;

    always @(negedge clk) begin
        beat_t e;
        cyc = cyc + 1;
        if (!aresetn) in_pkt = 0;
        if (c_m_axis_tvalid === 1'b1) begin
            if (!in_pkt) begin
                last_gap   = cyc - tlast_cyc - 1;
                last_hdr   = c_m_axis_tdata;
                last_tuser = c_m_axis_tuser;
                hdr_cyc    = cyc;
                hdr_count  = hdr_count + 1;
                cur_len    = 0;
                in_pkt     = 1;
            end
            cur_len = cur_len + 1;
            total = total + 1;
            if (sb.size() == 0) begin
                bad = bad + 1;
                $display("FAIL sb_unexpected_beat tdata=%h", c_m_axis_tdata);
            end else begin
                e = sb.pop_front();
                if (c_m_axis_tdata !== e.d || c_m_axis_tuser !== e.u ||
                    c_m_axis_tkeep !== 32'hFFFF_FFFF || c_m_axis_tlast !== e.l) begin
                    bad = bad + 1;
                    $display("FAIL sb_beat got d=%h u=%h k=%h l=%b exp d=%h u=%h k=ffffffff l=%b",
                             c_m_axis_tdata, c_m_axis_tuser[15:0], c_m_axis_tkeep, c_m_axis_tlast,
                             e.d, e.u[15:0], e.l);
                end
            end
            if (c_m_axis_tlast === 1'b1) begin
                in_pkt    = 0;
                tlast_cyc = cyc;
                pkt_len   = cur_len;
            end
        end else begin
            if (in_pkt) bubbles = bubbles + 1;
            total = total + 1;
            if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast} !== '0) begin
                bad = bad + 1;
                $display("FAIL idle_zero got d=%h u=%h k=%h l=%b exp all 0",
                         c_m_axis_tdata, c_m_axis_tuser[15:0], c_m_axis_tkeep, c_m_axis_tlast);
            end
        end
        if (pkt_done === 1'b1) begin
            done_cyc   = cyc;
            done_count = done_count + 1;
        end
        if (cmd_ready === 1'b1 && prev_rdy !== 1'b1) ready_delay = cyc - tlast_cyc;
        prev_rdy = cmd_ready;
    end

    // ---------------- stimulus helpers (drive at posedge+1) ----------------

    task automatic expect_pkt(input logic [7:0] st, input logic [7:0] rs, input logic [7:0] ix,
                              input logic [2:0] nb, input logic [255:0] w [4]);
        beat_t b;
        b.d = {208'd0, 5'd0, nb, ix, rs, st, 16'hF2F1};
        b.u = {112'd0, 16'(32 * (int'(nb) + 1))};
        b.l = 1'b0;
        sb.push_back(b);
        for (int k = 0; k < int'(nb); k++) begin
            b.d = w[k];
            b.l = (k == int'(nb) - 1);
            sb.push_back(b);
        end
    endtask

    task automatic do_cmd(input logic [7:0] st, input logic [7:0] rs, input logic [7:0] ix,
                          input logic [2:0] nb);
        int g = 0;
        while (cmd_ready !== 1'b1 && g < 200) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 200) begin
            total++; bad++;
            $display("FAIL cmd_ready_timeout got=0 exp=1");
        end
        cmd_stage_id    = st;
        cmd_resource_id = rs;
        cmd_index       = ix;
        cmd_nbeats      = nb;
        cmd_valid       = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_words(input logic [255:0] w [4], input int nb, input int stall_after,
                              input int stall_n, output int acc_cyc);
        acc_cyc = 0;
        for (int k = 0; k < nb; k++) begin
            int g = 0;
            wr_data       = w[k];
            wr_data_valid = 1'b1;
            while (wr_data_ready !== 1'b1 && g < 200) begin
                @(posedge clk); #1; g++;
            end
            if (g >= 200) begin
                total++; bad++;
                $display("FAIL wr_ready_timeout got=0 exp=1");
            end
            @(posedge clk); #1;
            acc_cyc       = cyc;
            wr_data_valid = 1'b0;
            if (k == stall_after) begin
                repeat (stall_n) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic wait_done();
        int s = done_count;
        int g = 0;
        while (done_count == s && g < 200) begin
            @(negedge clk); #1; g++;
        end
        if (g >= 200) begin
            total++; bad++;
            $display("FAIL pkt_done_timeout got=0 exp=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_words(output logic [255:0] w [4]);
        for (int k = 0; k < 4; k++)
            w[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // ---------------------------- tests ----------------------------------

    task automatic test_reset();
        aresetn = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        total++;
        if ({c_m_axis_tvalid, c_m_axis_tlast, pkt_done, cmd_err, busy, wr_data_ready} !== 6'b0 ||
            c_m_axis_tdata !== '0 || c_m_axis_tuser !== '0 || c_m_axis_tkeep !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b l=%b done=%b err=%b busy=%b wrr=%b exp all 0",
                     c_m_axis_tvalid, c_m_axis_tlast, pkt_done, cmd_err, busy, wr_data_ready);
        end
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        @(posedge clk); #1;
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got cmd_ready=%b busy=%b exp 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_single();
        logic [255:0] w [4];
        int acc;
        rand_words(w);
        expect_pkt(8'd2, 8'd1, 8'd5, 3'd1, w);
        do_cmd(8'd2, 8'd1, 8'd5, 3'd1);
        push_words(w, 1, -1, 0, acc);
        wait_done();
        total++;
        if (last_hdr[47:0] !== 48'h01_05_01_02_F2F1) begin
            bad++;
            $display("FAIL single_hdr got=%h exp=0105 0102f2f1", last_hdr[47:0]);
        end
        total++;
        if (last_tuser[15:0] !== 16'd64) begin
            bad++;
            $display("FAIL single_tuser got=%0d exp=64", last_tuser[15:0]);
        end
        total++;
        if (hdr_cyc != acc + 2) begin
            bad++;
            $display("FAIL single_hdr_latency got=%0d exp=%0d", hdr_cyc - acc, 2);
        end
        total++;
        if (pkt_len != 2 || done_cyc != tlast_cyc + 1) begin
            bad++;
            $display("FAIL single_len_done got len=%0d done_off=%0d exp len=2 done_off=1",
                     pkt_len, done_cyc - tlast_cyc);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL single_sb_left got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_stall();
        logic [255:0] w [4];
        int acc;
        int b0 = bubbles;
        rand_words(w);
        expect_pkt(8'd3, 8'd7, 8'd200, 3'd4, w);
        do_cmd(8'd3, 8'd7, 8'd200, 3'd4);
        push_words(w, 4, 0, 3, acc);
        wait_done();
        total++;
        if (pkt_len != 5 || bubbles != b0) begin
            bad++;
            $display("FAIL stall_contig got len=%0d bubbles=%0d exp len=5 bubbles=0",
                     pkt_len, bubbles - b0);
        end
        total++;
        if (last_tuser[15:0] !== 16'd160) begin
            bad++;
            $display("FAIL stall_tuser got=%0d exp=160", last_tuser[15:0]);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL stall_sb_left got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_illegal();
        logic [2:0] bad_nb [2];
        bad_nb[0] = 3'd0;
        bad_nb[1] = 3'd5;
        for (int i = 0; i < 2; i++) begin
            int h0 = hdr_count;
            do_cmd(8'd9, 8'd9, 8'd9, bad_nb[i]);
            total++;
            if (cmd_err !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL illegal_err nb=%0d got err=%b rdy=%b busy=%b exp 1 1 0",
                         bad_nb[i], cmd_err, cmd_ready, busy);
            end
            @(posedge clk); #1;
            total++;
            if (cmd_err !== 1'b0 || cmd_ready !== 1'b1) begin
                bad++;
                $display("FAIL illegal_pulse nb=%0d got err=%b rdy=%b exp 0 1",
                         bad_nb[i], cmd_err, cmd_ready);
            end
            repeat (6) begin @(posedge clk); #1; end
            total++;
            if (hdr_count != h0 || wr_data_ready !== 1'b0) begin
                bad++;
                $display("FAIL illegal_bus nb=%0d got pkts=%0d wrr=%b exp 0 0",
                         bad_nb[i], hdr_count - h0, wr_data_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] wa [4];
        logic [255:0] wb [4];
        int acc;
        rand_words(wa);
        rand_words(wb);
        expect_pkt(8'd1, 8'd2, 8'd3, 3'd2, wa);
        expect_pkt(8'd4, 8'd5, 8'd6, 3'd3, wb);
        do_cmd(8'd1, 8'd2, 8'd3, 3'd2);
        push_words(wa, 2, -1, 0, acc);
        do_cmd(8'd4, 8'd5, 8'd6, 3'd3);
        total++;
        if (ready_delay != 3) begin
            bad++;
            $display("FAIL b2b_ready_delay got=%0d exp=3", ready_delay);
        end
        push_words(wb, 3, -1, 0, acc);
        wait_done();
        total++;
        if (last_gap < 3) begin
            bad++;
            $display("FAIL b2b_gap got=%0d exp>=3", last_gap);
        end
        total++;
        if (sb.size() != 0 || pkt_len != 4) begin
            bad++;
            $display("FAIL b2b_sb got left=%0d len=%0d exp 0 4", sb.size(), pkt_len);
        end
    endtask

    task automatic test_busy_hold();
        logic [255:0] wa [4];
        logic [255:0] wb [4];
        int acc;
        int g = 0;
        rand_words(wa);
        rand_words(wb);
        expect_pkt(8'h07, 8'h11, 8'h09, 3'd2, wa);
        expect_pkt(8'hAA, 8'hBB, 8'hCC, 3'd1, wb);
        while (cmd_ready !== 1'b1 && g < 200) begin @(posedge clk); #1; g++; end
        cmd_stage_id = 8'h07; cmd_resource_id = 8'h11; cmd_index = 8'h09; cmd_nbeats = 3'd2;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_stage_id = 8'hAA; cmd_resource_id = 8'hBB; cmd_index = 8'hCC; cmd_nbeats = 3'd1;
        push_words(wa, 2, -1, 0, acc);
        g = 0;
        while (cmd_ready !== 1'b1 && g < 200) begin @(posedge clk); #1; g++; end
        total++;
        if ((cyc + 1) - tlast_cyc != 3) begin
            bad++;
            $display("FAIL hold_accept_time got=%0d exp=3", (cyc + 1) - tlast_cyc);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        push_words(wb, 1, -1, 0, acc);
        wait_done();
        total++;
        if (sb.size() != 0 || last_hdr[47:16] !== 32'h01_CC_BB_AA) begin
            bad++;
            $display("FAIL hold_fields got left=%0d hdr=%h exp 0 01ccbbaa", sb.size(), last_hdr[47:16]);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] w [4];
        logic [255:0] w2 [4];
        int acc;
        int g = 0;
        rand_words(w);
        rand_words(w2);
        expect_pkt(8'd5, 8'd6, 8'd7, 3'd4, w);
        do_cmd(8'd5, 8'd6, 8'd7, 3'd4);
        push_words(w, 4, -1, 0, acc);
        while (g < 30) begin
            @(negedge clk);
            if (c_m_axis_tvalid === 1'b1 && c_m_axis_tdata === w[1]) break;
            g++;
        end
        total++;
        if (g >= 30) begin
            bad++;
            $display("FAIL rstmid_beat2_timeout got=none exp=beat2");
        end
        #2 aresetn = 1'b0;
        #1;
        total++;
        if ({c_m_axis_tvalid, c_m_axis_tlast, pkt_done, cmd_err, busy} !== 5'b0 ||
            c_m_axis_tdata !== '0 || c_m_axis_tuser !== '0 || c_m_axis_tkeep !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs got v=%b l=%b d=%h k=%h busy=%b exp all 0",
                     c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tdata, c_m_axis_tkeep, busy);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        @(posedge clk); #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ready got=%b exp=1", cmd_ready);
        end
        expect_pkt(8'd8, 8'd9, 8'd10, 3'd3, w2);
        do_cmd(8'd8, 8'd9, 8'd10, 3'd3);
        push_words(w2, 3, 1, 1, acc);
        wait_done();
        total++;
        if (sb.size() != 0 || pkt_len != 4) begin
            bad++;
            $display("FAIL rstmid_fresh got left=%0d len=%0d exp 0 4", sb.size(), pkt_len);
        end
    endtask

    initial begin
        cmd_stage_id    = '0;
        cmd_resource_id = '0;
        cmd_index       = '0;
        cmd_nbeats      = '0;
        cmd_valid       = 1'b0;
        wr_data         = '0;
        wr_data_valid   = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_busy_hold();
        test_reset_mid();
        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ctrl_pkt_tx.md
# ctrl_pkt_tx

Control-path packet transmitter for the RMT pipeline. It accepts table-write commands with their payload words and buffers each complete payload. It then emits one AXI-Stream control packet as a single contiguous burst on the `c_m_axis_*` bus that feeds the first stage's `c_s_axis_*` inputs. The control path has no `tready`, so this block alone guarantees gap-free packets and idle spacing between packets.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, 256: control bus width. Must be 256.
- `C_S_AXIS_TUSER_WIDTH`, 128: tuser width.
- `MAX_BEATS`, 4: maximum number of payload beats per packet.
- `GAP_CYCLES`, 2: minimum number of idle cycles after each `tlast`. Must be at least 1.
- `CTRL_TAG`, 16'hF2F1: tag placed in header bits [15:0].

Ports (`NBW = $clog2(MAX_BEATS)+1`):
- `axis_clk`  in  1: the single clock.
- `aresetn`  in  1: reset, asynchronous and active-low.
- `cmd_stage_id`  in  8: target stage.
- `cmd_resource_id`  in  8: target resource within the stage.
- `cmd_index`  in  8: table entry index.
- `cmd_nbeats`  in  NBW: number of payload beats, legal range 1..MAX_BEATS.
- `cmd_valid` / `cmd_ready`  in / out  1: command handshake.
- `wr_data`  in  256: payload word.
- `wr_data_valid` / `wr_data_ready`  in / out  1: payload handshake.
- `c_m_axis_tdata`  out  256: control stream data.
- `c_m_axis_tuser`  out  128: control stream user field.
- `c_m_axis_tkeep`  out  32: control stream byte enables.
- `c_m_axis_tvalid`  out  1: control stream valid.
- `c_m_axis_tlast`  out  1: control stream last beat.
- `busy`  out  1: high in every state except IDLE.
- `pkt_done`  out  1: one-cycle pulse after a packet completes.
- `cmd_err`  out  1: one-cycle pulse when an illegal command is rejected.

## Operation
- FSM states: IDLE, LOAD, HDR, DATA, GAP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch all `cmd_*` fields.
  - If `cmd_nbeats`==0 or `cmd_nbeats`>MAX_BEATS: pulse `cmd_err` next cycle and stay in IDLE.
  - Otherwise: clear the load counter and go to LOAD.
- **LOAD**
  - `wr_data_ready`=1.
  - Each accepted word is written to `buf[cnt]` and `cnt` increments.
  - When the word with `cnt`==nbeats-1 is accepted, go to HDR.
  - `wr_data_ready` is 0 in every other state; `cmd_ready` is 0 in every state except IDLE.
- **HDR**
  - Drive the header beat for exactly one cycle: `tvalid`=1, `tlast`=0.
  - Header tdata fields: [15:0] CTRL_TAG, [23:16] stage_id, [31:24] resource_id, [39:32] index, [47:40] zero-extended nbeats, all other bits 0.
  - Go to DATA with the beat counter at 0.
- **DATA**
  - Drive `buf[k]`, one beat per cycle, with no gaps.
  - `tlast`=1 only on beat nbeats-1; after that beat, go to GAP.
- **GAP**
  - `tvalid`=0 for GAP_CYCLES cycles, then go to IDLE.
  - `pkt_done` pulses in the first GAP cycle.
- Fields common to every beat of a packet:
  - `tkeep`=32'hFFFFFFFF.
  - `tuser`[15:0] = 32*(nbeats+1), the packet length in bytes; remaining tuser bits are 0.
- When `tvalid`=0: tdata, tuser, tkeep and tlast are all driven to 0.
- Asserting `aresetn` low in any state, including mid-packet, must:
  - abort the packet;
  - clear all outputs to 0 asynchronously;
  - return the FSM to IDLE.
- Payload buffer contents need no reset.

## Timing
- All `c_m_axis_*` outputs, `pkt_done` and `cmd_err` are registered.
- Reset values: every output is 0, except `cmd_ready`, which is 1 once the FSM is in IDLE. `cmd_ready` is combinational from the state.
- Cycle-level sequence:
  - Command accepted at edge t0.
  - Earliest data word accepted at edge t0+1.
  - Final data word accepted at edge tL.
  - Header `tvalid` is high in the cycle after edge tL+1.
  - Payload beats follow in the next N cycles.
- Packet length is exactly N+1 consecutive valid cycles.
- `pkt_done` goes high in the cycle after the `tlast` cycle.
- Back-to-back commands: the next `cmd_ready` is high GAP_CYCLES+1 cycles after the `tlast` cycle. Consecutive packets are therefore separated by at least GAP_CYCLES+1 idle bus cycles.
- Gaps in `wr_data_valid` during LOAD stall LOAD only; they never produce a bubble inside a packet.

## Structure
- Shared package `ctrl_pkt_pkg` holds:
  - header field offsets (TAG_LSB=0, STAGE_LSB=16, RES_LSB=24, IDX_LSB=32, NB_LSB=40);
  - the default CTRL_TAG;
  - the state enum.
- Natural sub-module: `ctrl_payload_buf`, a MAX_BEATS×256 register file with one write port and one read port.
- FSM and counters live in the top level.

## Test plan
- Single write, nbeats=1, stage=2, res=1, idx=5, data=D0: expect 2 beats.
  - Header tdata[47:0]=48'h01_05_01_02_F2F1, tuser[15:0]=64.
  - Beat 2 = D0 with tlast=1; `pkt_done` one cycle later.
- nbeats=4, with `wr_data_valid` held low for 3 cycles between words 1 and 2: expect exactly 5 contiguous beats, tuser=160, no mid-packet bubble.
- Illegal commands: nbeats=0, and nbeats=5 with MAX_BEATS=4 → `cmd_err` pulses, no bus activity, `cmd_ready` stays high.
- Two back-to-back commands with GAP_CYCLES=2 → at least 3 idle cycles between the first `tlast` and the second header.
- `aresetn` pulsed low during beat 2 of 4 → all outputs 0 immediately. A fresh command afterwards produces a clean, complete packet.
- `cmd_valid` held high while the block is busy → the command is not accepted until IDLE, and the latched fields of the in-flight packet stay unchanged.
